// File: rtl/trigger_readout_sequencer.sv
// Trigger readout sequencer: freezes an event window from the sample ring buffer and streams header + samples.
// Optional macro READOUT_CHECKSUM_EN appends a 16-bit sum-of-words checksum as the final word of each event.
module trigger_readout_sequencer #(
  parameter int          ADDR_W    = 9,
  parameter int          PRETRIG   = 64,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic              CLK,
  input  logic              SOFT_RESET,
  input  logic              TRIGGER_OUT,
  input  logic              LIVE_ACQUISITION,
  input  logic              read_mode,
  input  logic [ADDR_W-1:0] WR_PTR,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [15:0]       RD_DATA,
  output logic [15:0]       TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              TX_LAST,
  output logic              SELF_TRIGGER_RESET,
  output logic              BUSY,
  output logic [15:0]       EVENT_COUNT
);

`ifdef READOUT_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  localparam int              IdxW    = ADDR_W + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WINDOW - 1);
  localparam logic [15:0]     LenWord = 16'(WINDOW);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, SEND, CSUM, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       tsCnt_q;
  logic              trig_q;
  logic [15:0]       evtCnt_q, evtCnt_d;
  logic [31:0]       tsLat_q, tsLat_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              mode_q, mode_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        hdrIdx_q, hdrIdx_d;
  logic [15:0]       txData_q, txData_d;
  logic              txValid_q, txValid_d;
  logic              txLast_q, txLast_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [15:0]       csum_q, csum_d;
  logic              abort_q, abort_d;

  logic rise, xfer, abortReq, wordState;

  always_comb begin
    rise      = TRIGGER_OUT & ~trig_q;
    xfer      = txValid_q & TX_READY;
    abortReq  = abort_q | ~TRIGGER_OUT;
    wordState = (state_q == HDR) || (state_q == SEND) || (state_q == CSUM);

    state_d   = state_q;
    evtCnt_d  = evtCnt_q;
    tsLat_d   = tsLat_q;
    start_d   = start_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    hdrIdx_d  = hdrIdx_q;
    txData_d  = txData_q;
    txValid_d = txValid_q;
    txLast_d  = txLast_q;
    rdAddr_d  = rdAddr_q;
    csum_d    = csum_q;
    abort_d   = abort_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HDR;
          tsLat_d   = tsCnt_q;
          start_d   = WR_PTR - ADDR_W'(PRETRIG);
          mode_d    = read_mode;
          evtCnt_d  = evtCnt_q + 16'd1;
          hdrIdx_d  = 3'd0;
          idx_d     = '0;
          txData_d  = SYNC_WORD;
          txValid_d = 1'b1;
          txLast_d  = 1'b0;
          csum_d    = 16'd0;
          abort_d   = 1'b0;
        end
      end

      HDR, SEND, CSUM: begin
        // Once an abort is seen the held word is closed with TX_LAST and the event ends on its transfer.
        if (abortReq) begin
          if (xfer) begin
            state_d   = IDLE;
            txValid_d = 1'b0;
            txLast_d  = 1'b0;
            abort_d   = 1'b0;
          end else begin
            txLast_d = 1'b1;
            abort_d  = 1'b1;
          end
        end else if (xfer) begin
          csum_d = csum_q + txData_q;
          if (state_q == HDR && hdrIdx_q != 3'd4) begin
            hdrIdx_d = hdrIdx_q + 3'd1;
            txLast_d = (hdrIdx_q == 3'd3) && mode_q && !CsumEn;
            case (hdrIdx_q)
              3'd0:    txData_d = evtCnt_q;
              3'd1:    txData_d = tsLat_q[31:16];
              3'd2:    txData_d = tsLat_q[15:0];
              default: txData_d = mode_q ? 16'd0 : LenWord;
            endcase
          end else if (state_q == HDR && !mode_q) begin
            state_d   = FETCH;
            txValid_d = 1'b0;
            rdAddr_d  = start_q + idx_q[ADDR_W-1:0];
          end else if (state_q == SEND && idx_q != LastIdx) begin
            state_d   = FETCH;
            txValid_d = 1'b0;
            txLast_d  = 1'b0;
            idx_d     = idx_q + IdxW'(1);
            rdAddr_d  = start_q + idx_q[ADDR_W-1:0] + ADDR_W'(1);
          end else if (state_q != CSUM && CsumEn) begin
            state_d  = CSUM;
            txData_d = csum_q + txData_q;
            txLast_d = 1'b1;
          end else begin
            state_d   = DONE;
            txValid_d = 1'b0;
            txLast_d  = 1'b0;
          end
        end
      end

      FETCH: begin
        state_d = TRIGGER_OUT ? LATCH : IDLE;
      end

      LATCH: begin
        if (!TRIGGER_OUT) begin
          state_d = IDLE;
        end else begin
          state_d   = SEND;
          txData_d  = RD_DATA;
          txValid_d = 1'b1;
          txLast_d  = (idx_q == LastIdx) && !CsumEn;
        end
      end

      DONE: begin
        if (!TRIGGER_OUT || LIVE_ACQUISITION) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SOFT_RESET) begin
      state_q   <= IDLE;
      tsCnt_q   <= '0;
      trig_q    <= 1'b0;
      evtCnt_q  <= '0;
      tsLat_q   <= '0;
      start_q   <= '0;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      hdrIdx_q  <= '0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
      txLast_q  <= 1'b0;
      rdAddr_q  <= '0;
      csum_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tsCnt_q   <= tsCnt_q + 32'd1;
      trig_q    <= TRIGGER_OUT;
      evtCnt_q  <= evtCnt_d;
      tsLat_q   <= tsLat_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      hdrIdx_q  <= hdrIdx_d;
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
      txLast_q  <= txLast_d;
      rdAddr_q  <= rdAddr_d;
      csum_q    <= csum_d;
      abort_q   <= abort_d;
    end
  end

  // A falling trigger marks the word on the bus as last in the same cycle, so an immediate accept still closes the frame.
  assign TX_LAST            = txLast_q | (txValid_q & ~TRIGGER_OUT & wordState);
  assign TX_DATA            = txData_q;
  assign TX_VALID           = txValid_q;
  assign RD_ADDR            = rdAddr_q;
  assign SELF_TRIGGER_RESET = (state_q == DONE);
  assign BUSY               = (state_q != IDLE);
  assign EVENT_COUNT        = evtCnt_q;

endmodule

// File: tb/tb_trigger_readout_sequencer.sv
// Directed bench for trigger_readout_sequencer: a scoreboard queue of expected words is filled on each trigger
// and drained by a monitor on every accepted word; state outputs are checked at fixed points in between.
module tb_trigger_readout_sequencer;
  localparam int          ADDR_W  = 9;
  localparam int          PRETRIG = 64;
  localparam int          WINDOW  = 256;
  localparam logic [15:0] SYNC    = 16'hEB90;

`ifdef READOUT_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              SOFT_RESET, TRIGGER_OUT, LIVE_ACQUISITION, read_mode, TX_READY;
  logic [ADDR_W-1:0] WR_PTR, RD_ADDR;
  logic [15:0]       RD_DATA, TX_DATA, EVENT_COUNT;
  logic              TX_VALID, TX_LAST, SELF_TRIGGER_RESET, BUSY;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t       expQ[$];
  int          popCnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          evtExp = 0;
  logic [15:0] runSum;
  logic [31:0] tbTs;

  trigger_readout_sequencer #(
    .ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .WINDOW(WINDOW), .SYNC_WORD(SYNC)
  ) dut (
    .CLK(CLK), .SOFT_RESET(SOFT_RESET), .TRIGGER_OUT(TRIGGER_OUT),
    .LIVE_ACQUISITION(LIVE_ACQUISITION), .read_mode(read_mode), .WR_PTR(WR_PTR),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_LAST(TX_LAST), .SELF_TRIGGER_RESET(SELF_TRIGGER_RESET),
    .BUSY(BUSY), .EVENT_COUNT(EVENT_COUNT)
  );

  always #5 CLK = ~CLK;

  // Each ring-buffer address holds a distinct value, so a wrong read address shows up as a data error
  function automatic logic [15:0] ramVal(input logic [ADDR_W-1:0] a);
    return 16'(32'(a) * 37 + 100);
  endfunction

  always @(posedge CLK) RD_DATA <= ramVal(RD_ADDR);

  // Reference timestamp: cleared by reset, +1 on every other edge
  always @(posedge CLK) begin
    if (SOFT_RESET) tbTs <= 32'd0;
    else            tbTs <= tbTs + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [15:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    expQ.push_back(w);
    runSum = runSum + d;
  endtask

  // Raise the trigger and queue every word the event should produce
  task automatic applyStimulus(input logic [ADDR_W-1:0] ptr, input logic mode,
                               input int nSamples, input bit aborted);
    logic [31:0]       ts;
    logic [ADDR_W-1:0] start;
    logic [15:0]       s;
    @(posedge CLK); #1;
    WR_PTR      = ptr;
    read_mode   = mode;
    TRIGGER_OUT = 1'b1;
    ts          = tbTs;
    evtExp++;
    popCnt = 0;
    runSum = 16'd0;
    start  = ptr - ADDR_W'(PRETRIG);
    pushWord(SYNC, 1'b0);
    pushWord(16'(evtExp), 1'b0);
    pushWord(ts[31:16], 1'b0);
    pushWord(ts[15:0], 1'b0);
    pushWord(mode ? 16'd0 : 16'(WINDOW), mode && !CsumEn);
    if (!mode) begin
      for (int i = 0; i < nSamples; i++) begin
        pushWord(ramVal(start + ADDR_W'(i)),
                 aborted ? (i == nSamples - 1) : ((i == WINDOW - 1) && !CsumEn));
      end
    end
    if (CsumEn && !aborted) begin
      s = runSum;
      pushWord(s, 1'b1);
    end
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(posedge CLK);
    checkOutput({tag, "_drained"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitPopCnt(input string tag, input int target);
    for (int i = 0; i < 2000 && popCnt != target; i++) @(posedge CLK);
    checkOutput({tag, "_reached"}, popCnt, target);
  endtask

  task automatic waitValid(input string tag);
    int i;
    for (i = 0; i < 50 && TX_VALID !== 1'b1; i++) @(negedge CLK);
    checkOutput({tag, "_valid"}, TX_VALID, 1);
  endtask

  // Normal end of event: DONE pulse, trigger released, back to IDLE one cycle later
  task automatic finishEvent(input string tag, input int evt);
    @(negedge CLK);
    checkOutput({tag, "_str_high"}, SELF_TRIGGER_RESET, 1);
    checkOutput({tag, "_busy_done"}, BUSY, 1);
    @(posedge CLK); #1;
    TRIGGER_OUT = 1'b0;
    @(negedge CLK);
    checkOutput({tag, "_str_hold"}, SELF_TRIGGER_RESET, 1);
    @(negedge CLK);
    checkOutput({tag, "_str_low"}, SELF_TRIGGER_RESET, 0);
    checkOutput({tag, "_busy_idle"}, BUSY, 0);
    checkOutput({tag, "_evcount"}, EVENT_COUNT, evt);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_tx_valid"}, TX_VALID, 0);
    checkOutput({tag, "_tx_data"}, TX_DATA, 0);
    checkOutput({tag, "_tx_last"}, TX_LAST, 0);
    checkOutput({tag, "_rd_addr"}, RD_ADDR, 0);
    checkOutput({tag, "_str"}, SELF_TRIGGER_RESET, 0);
    checkOutput({tag, "_busy"}, BUSY, 0);
    checkOutput({tag, "_evcount"}, EVENT_COUNT, 0);
  endtask

  // Scoreboard: every accepted word must match the head of the expected queue
  always @(negedge CLK) begin
    if (!SOFT_RESET && TX_VALID === 1'b1 && TX_READY === 1'b1) begin
      word_t w;
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_word observed=%h expected=none", TX_DATA);
      end
      if (expQ.size() != 0) begin
        w = expQ.pop_front();
        checkOutput($sformatf("word%0d_data", popCnt), TX_DATA, w.data);
        checkOutput($sformatf("word%0d_last", popCnt), TX_LAST, w.last);
        popCnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0]       heldData;
    logic              heldLast;
    logic [ADDR_W-1:0] heldAddr, rdBefore;
    int                strSeen;

    SOFT_RESET       = 1'b1;
    TRIGGER_OUT      = 1'b0;
    LIVE_ACQUISITION = 1'b0;
    read_mode        = 1'b0;
    TX_READY         = 1'b1;
    WR_PTR           = '0;
    repeat (3) @(posedge CLK);
    #1 SOFT_RESET = 1'b0;
    @(negedge CLK);
    checkIdleOutputs("por");

    // Event 1: full readout across the ring-buffer wrap (458..511, 0..201)
    applyStimulus(9'd10, 1'b0, WINDOW, 1'b0);
    waitDrain("ev1", 2000);
    finishEvent("ev1", 1);

    // Event 2: abort while sample 20 is held on the bus
    applyStimulus(9'd100, 1'b0, 21, 1'b1);
    waitPopCnt("ev2_pop20", 25);
    #1 TX_READY = 1'b0;
    waitValid("ev2_s20");
    @(posedge CLK); #1;
    TRIGGER_OUT = 1'b0;
    @(negedge CLK);
    checkOutput("ev2_forced_last", TX_LAST, 1);
    checkOutput("ev2_data_held", TX_DATA, ramVal(9'd36 + 9'd20));
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    waitDrain("ev2", 50);
    strSeen = 0;
    repeat (5) begin
      @(negedge CLK);
      if (SELF_TRIGGER_RESET === 1'b1) strSeen++;
    end
    checkOutput("ev2_no_str", strSeen, 0);
    checkOutput("ev2_busy_idle", BUSY, 0);
    checkOutput("ev2_evcount", EVENT_COUNT, 2);

    // Event 3: header only, left via the re-arm status while the trigger is still high
    rdBefore = RD_ADDR;
    applyStimulus(9'd200, 1'b1, 0, 1'b0);
    waitDrain("ev3", 100);
    checkOutput("ev3_words", popCnt, 5 + int'(CsumEn));
    checkOutput("ev3_rdaddr_idle", RD_ADDR, rdBefore);
    @(negedge CLK);
    checkOutput("ev3_str_high", SELF_TRIGGER_RESET, 1);
    @(posedge CLK); #1;
    LIVE_ACQUISITION = 1'b1;
    @(negedge CLK);
    checkOutput("ev3_str_hold", SELF_TRIGGER_RESET, 1);
    @(negedge CLK);
    checkOutput("ev3_str_low", SELF_TRIGGER_RESET, 0);
    checkOutput("ev3_busy_idle", BUSY, 0);
    @(posedge CLK); #1;
    LIVE_ACQUISITION = 1'b0;
    TRIGGER_OUT      = 1'b0;
    repeat (2) @(posedge CLK);

    // Event 4: ten-ish cycles of backpressure on sample 7 (start = 436)
    applyStimulus(9'd500, 1'b0, WINDOW, 1'b0);
    waitPopCnt("ev4_pop7", 12);
    #1 TX_READY = 1'b0;
    waitValid("ev4_s7");
    heldData = TX_DATA;
    heldLast = TX_LAST;
    heldAddr = RD_ADDR;
    checkOutput("ev4_s7_data", heldData, ramVal(9'd443));
    checkOutput("ev4_s7_addr", heldAddr, 9'd443);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("ev4_hold%0d_data", i), TX_DATA, heldData);
      checkOutput($sformatf("ev4_hold%0d_last", i), TX_LAST, heldLast);
      checkOutput($sformatf("ev4_hold%0d_addr", i), RD_ADDR, heldAddr);
    end
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    waitDrain("ev4", 2000);
    checkOutput("ev4_words", popCnt, 261 + int'(CsumEn));
    finishEvent("ev4", 4);

    // Reset in the middle of idle clears the counter and every output
    @(posedge CLK); #1;
    SOFT_RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkIdleOutputs("midreset");
    @(posedge CLK); #1;
    SOFT_RESET = 1'b0;
    evtExp = 0;
    repeat (3) @(posedge CLK);

    // Event after reset: numbering and timestamp restart
    applyStimulus(9'd0, 1'b1, 0, 1'b0);
    waitDrain("ev5", 100);
    finishEvent("ev5", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
